// File: rtl/bcd_sum_collector_if.sv
// Digit-in / frame-out handshake bundle for bcd_sum_collector.
// The master modport is the upstream adder plus downstream consumer; slave is the collector.
interface bcd_sum_collector_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              in_digit;
  logic                    in_carry;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_DIGITS-1:0] out_bcd;
  logic                    out_carry;
  logic [CW-1:0]           out_count;
  logic                    err;

  modport master (
    output in_valid, in_digit, in_carry, in_last, out_ready,
    input  in_ready, out_valid, out_bcd, out_carry, out_count, err
  );

  modport slave (
    input  in_valid, in_digit, in_carry, in_last, out_ready,
    output in_ready, out_valid, out_bcd, out_carry, out_count, err
  );
endinterface

// File: rtl/bcd_sum_collector.sv
// Collects LSD-first BCD digit sums into one packed frame and holds it until consumed.
// Optional macro BCD_COLLECT_CHECK_EN flags frames that contain a non-BCD digit on err.
module bcd_sum_collector #(
  parameter int NUM_DIGITS = 4
) (
  input logic               clk,
  input logic               rst,
  bcd_sum_collector_if.slave bus
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                      state, stateNext;
  logic [CW-1:0]               idx;
  logic [NUM_DIGITS-1:0][3:0]  digits;
  logic                        carryReg;
  logic                        accept;
  logic                        frameEnd;
  logic                        consume;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    accept       = 1'b0;
    frameEnd     = 1'b0;
    consume      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        frameEnd     = accept && (bus.in_last || idx == CW'(NUM_DIGITS - 1));
        if (frameEnd) stateNext = HOLD;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        consume       = bus.out_ready;
        if (consume) stateNext = COLLECT;
      end
      default: stateNext = COLLECT;
    endcase
  end

  // Only the final digit's carry is kept; earlier carries were already rippled upstream.
  always_ff @(posedge clk) begin
    if (rst || consume) begin
      idx      <= '0;
      digits   <= '0;
      carryReg <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (idx == CW'(i)) digits[i] <= bus.in_digit;
      idx <= idx + CW'(1);
      if (frameEnd) carryReg <= bus.in_carry;
    end
  end

`ifdef BCD_COLLECT_CHECK_EN
  logic errReg;

  always_ff @(posedge clk) begin
    if (rst || consume)                  errReg <= 1'b0;
    else if (accept && bus.in_digit > 4'd9) errReg <= 1'b1;
  end

  assign bus.err = errReg;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.out_bcd   = digits;
  assign bus.out_carry = carryReg;
  assign bus.out_count = idx;
endmodule

// File: tb/tb_bcd_sum_collector.sv
// Directed-vector bench for bcd_sum_collector: a frame-level reference model is
// checked against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_bcd_sum_collector;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nPass   = 0;
  bit   started = 1'b0;

  bcd_sum_collector_if #(.NUM_DIGITS(N)) bus();

  bcd_sum_collector #(.NUM_DIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of digits; the packed result is plain arithmetic.
  int unsigned mDigits[$];
  bit          mHold  = 1'b0;
  bit          mCarry = 1'b0;
  bit          mErr   = 1'b0;

  function automatic int unsigned packedBcd();
    int unsigned e = 0;
    foreach (mDigits[i]) e += mDigits[i] * (16 ** i);
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mDigits.delete();
      mHold  = 1'b0;
      mCarry = 1'b0;
      mErr   = 1'b0;
      started = 1'b1;
    end else if (!mHold) begin
      if (bus.in_valid) begin
        mDigits.push_back(int'(bus.in_digit));
`ifdef BCD_COLLECT_CHECK_EN
        if (bus.in_digit > 9) mErr = 1'b1;
`endif
        if (bus.in_last || mDigits.size() == N) begin
          mHold  = 1'b1;
          mCarry = bus.in_carry;
        end
      end
    end else if (bus.out_ready) begin
      mDigits.delete();
      mHold  = 1'b0;
      mCarry = 1'b0;
      mErr   = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m.in_ready",  32'(bus.in_ready),  32'(!mHold));
      chk("m.out_valid", 32'(bus.out_valid), 32'(mHold));
      chk("m.out_bcd",   32'(bus.out_bcd),   packedBcd());
      chk("m.out_count", 32'(bus.out_count), 32'(mDigits.size()));
      chk("m.out_carry", 32'(bus.out_carry), 32'(mCarry));
      chk("m.err",       32'(bus.err),       32'(mErr));
    end
  end

  // One cycle of stimulus, applied at the falling edge.
  task automatic cyc(input bit r, input bit v, input logic [3:0] d, input bit c,
                     input bit l, input bit ordy);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_digit  = d;
    bus.in_carry  = c;
    bus.in_last   = l;
    bus.out_ready = ordy;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_digit  = 4'd0;
    bus.in_carry  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_bcd",   32'(bus.out_bcd),   32'd0);
    chk("rst.out_count", 32'(bus.out_count), 32'd0);

    // single-digit frame
    cyc(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk("one.out_valid", 32'(bus.out_valid), 32'd1);
    chk("one.out_bcd",   32'(bus.out_bcd),   32'h0001);
    chk("one.out_carry", 32'(bus.out_carry), 32'd1);
    chk("one.out_count", 32'(bus.out_count), 32'd1);
    idle(1'b1);
    idle(1'b0);
    chk("one.cleared", 32'(bus.out_bcd), 32'd0);

    // forced end after NUM_DIGITS digits, out_ready held high while collecting
    cyc(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("full.out_bcd",   32'(bus.out_bcd),   32'h5432);
    chk("full.out_count", 32'(bus.out_count), 32'd4);
    chk("full.out_carry", 32'(bus.out_carry), 32'd1);

    // backpressure in HOLD with in_valid pulsing
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'(i % 2), 4'd7, 1'b0, 1'b1, 1'b0);
    chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
    chk("hold.in_ready",  32'(bus.in_ready),  32'd0);
    chk("hold.out_bcd",   32'(bus.out_bcd),   32'h5432);
    idle(1'b1);
    cyc(1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("after.out_bcd",   32'(bus.out_bcd),   32'h0008);
    chk("after.out_count", 32'(bus.out_count), 32'd1);
    idle(1'b1);

    // reset mid-frame, with a simultaneous digit that must be dropped
    cyc(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk("mid.out_bcd",   32'(bus.out_bcd),   32'd0);
    chk("mid.out_count", 32'(bus.out_count), 32'd0);
    chk("mid.out_valid", 32'(bus.out_valid), 32'd0);
    cyc(1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("mid2.out_bcd",   32'(bus.out_bcd),   32'h0007);
    chk("mid2.out_count", 32'(bus.out_count), 32'd1);
    // reset while holding
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("rsthold.out_valid", 32'(bus.out_valid), 32'd0);

    // non-BCD digit
    cyc(1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("bad.out_bcd", 32'(bus.out_bcd), 32'h000C);
`ifdef BCD_COLLECT_CHECK_EN
    chk("bad.err", 32'(bus.err), 32'd1);
`else
    chk("bad.err", 32'(bus.err), 32'd0);
`endif
    idle(1'b1);
    idle(1'b0);
    chk("bad.err_clear", 32'(bus.err), 32'd0);

    // gaps between digits
    cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    chk("gap.out_bcd",   32'(bus.out_bcd),   32'h0099);
    chk("gap.out_count", 32'(bus.out_count), 32'd2);
    chk("gap.out_carry", 32'(bus.out_carry), 32'd1);
    idle(1'b1);
    idle(1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/bcd_sum_collector.md
BCD_SUM_COLLECTOR -- requirements
Module: bcd_sum_collector

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning the digit capacity of one result frame (legal range 2..8).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  a digit result from the upstream BCD adder stage is present.
REQ-005 The block SHALL have port in_ready  output  1  the block accepts a digit this cycle.
REQ-006 The block SHALL have port in_digit  input  4  BCD digit sum from the adder (FirstSums), least-significant digit first.
REQ-007 The block SHALL have port in_carry  input  1  decimal carry out of that digit (FirstCarry).
REQ-008 The block SHALL have port in_last  input  1  the digit is the final digit of the frame.
REQ-009 The block SHALL have port out_valid  output  1  a complete result frame is held.
REQ-010 The block SHALL have port out_ready  input  1  the downstream stage consumes the frame.
REQ-011 The block SHALL have port out_bcd  output  4*NUM_DIGITS  packed BCD result; digit i occupies bits [4i+3:4i].
REQ-012 The block SHALL have port out_carry  output  1  carry of the final accepted digit (decimal overflow).
REQ-013 The block SHALL have port out_count  output  $clog2(NUM_DIGITS+1)  number of digits accepted in the frame.
REQ-014 The block SHALL have port err  output  1  the frame contained a non-BCD digit (see Configuration).

Function
REQ-015 The block SHALL implement two states, COLLECT and HOLD; in_ready SHALL be 1 exactly in COLLECT and out_valid SHALL be 1 exactly in HOLD, both decoded combinationally from the state register.
REQ-016 In COLLECT, a digit SHALL be accepted on any edge with in_valid=1; it SHALL be written to digit position idx, idx SHALL increment, and out_count SHALL equal idx.
REQ-017 The frame SHALL end on the accepting edge when in_last=1 or idx=NUM_DIGITS-1; on that edge out_carry SHALL load in_carry and the state SHALL go to HOLD.
REQ-018 Latency: if the last digit is accepted at edge k, out_valid SHALL be 1 from the cycle after edge k.
REQ-019 Carries of non-final digits SHALL NOT be stored; the upstream stage ripples them.
REQ-020 Digit positions not written in a frame SHALL read 0.
REQ-021 In HOLD, out_bcd, out_carry, out_count and err SHALL be stable; in_valid SHALL be ignored.
REQ-022 In HOLD, on an edge with out_ready=1, the state SHALL return to COLLECT and idx, out_bcd, out_carry, out_count and err SHALL clear to 0.
REQ-023 In COLLECT, out_ready SHALL be ignored.
REQ-024 Gaps (in_valid=0) between digits SHALL NOT affect the result.
REQ-025 in_digit SHALL be stored unmodified; the block SHALL perform no arithmetic correction.

Reset
REQ-026 rst=1 at an edge SHALL force state COLLECT, idx=0, out_bcd=0, out_carry=0, out_count=0 and err=0, overriding any simultaneous handshake.
REQ-027 Reset mid-frame or in HOLD SHALL discard the partial or held frame, and the next accepted digit SHALL go to position 0.

Configuration
REQ-028 With macro BCD_COLLECT_CHECK_EN defined, err SHALL become 1 on the edge accepting any digit with in_digit>9 and SHALL stay 1 until the frame is consumed or reset.
REQ-029 Without BCD_COLLECT_CHECK_EN, err SHALL be constant 0 and no check logic SHALL be synthesised; all other behaviour is identical.

Verification
REQ-030 Single-digit frame (5+6 result): in_digit=1, in_carry=1, in_last=1 -> next cycle out_valid=1, out_bcd=16'h0001, out_carry=1, out_count=1.
REQ-031 Digits 2,3,4,5 with in_last=0 throughout -> frame ends forcibly after the 4th digit; out_bcd=16'h5432, out_count=4, out_carry equals the 4th in_carry.
REQ-032 out_ready held low for 5 cycles in HOLD with in_valid pulsing -> out_valid stays 1, in_ready stays 0, outputs unchanged; after out_ready=1 a digit is accepted on the next edge at position 0.
REQ-033 rst pulsed after 2 accepted digits -> all outputs 0; a following frame 7 (in_last=1) gives out_bcd=16'h0007, out_count=1.
REQ-034 Digit 4'hC accepted -> err=1 in HOLD with BCD_COLLECT_CHECK_EN defined, err=0 without it; err=0 after consumption.
REQ-035 Digits 9,9 with idle cycles between them and in_last=1 on the second -> out_bcd=16'h0099, out_count=2.
